// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU stage and a word-addressed RAM with 1-cycle registered read.
// Byte/half/word accesses; sub-word stores are read-modify-write, misaligned requests return an error.
module mem_access_unit #(
    parameter int ADDR_W     = 32,
    parameter int RAM_ADDR_W = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_wren,
    output logic [RAM_ADDR_W-1:0] ram_address,
    output logic [31:0]           ram_data,
    input  logic [31:0]           ram_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_WRITE,
        S_RESP,
        S_ERR
    } state_t;

    state_t            state_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;

    logic              req_bad_d;
    logic [7:0]        lane_byte_d;
    logic [15:0]       lane_half_d;
    logic [31:0]       load_data_d;
    logic [31:0]       merge_data_d;

    always_comb begin
        req_bad_d = 1'b0;
        case (req_size)
            2'b01:   req_bad_d = req_addr[0];
            2'b10:   req_bad_d = (req_addr[1:0] != 2'b00);
            2'b11:   req_bad_d = 1'b1;
            default: req_bad_d = 1'b0;
        endcase
    end

    // Lane extraction and store merge both work on the word returned by the RAM in CAPTURE.
    always_comb begin
        lane_byte_d = ram_q[7:0];
        case (addr_q[1:0])
            2'd1:    lane_byte_d = ram_q[15:8];
            2'd2:    lane_byte_d = ram_q[23:16];
            2'd3:    lane_byte_d = ram_q[31:24];
            default: lane_byte_d = ram_q[7:0];
        endcase
        lane_half_d = addr_q[1] ? ram_q[31:16] : ram_q[15:0];

        case (size_q)
            2'b00:   load_data_d = {{24{signed_q & lane_byte_d[7]}}, lane_byte_d};
            2'b01:   load_data_d = {{16{signed_q & lane_half_d[15]}}, lane_half_d};
            default: load_data_d = ram_q;
        endcase

        merge_data_d = ram_q;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd1:    merge_data_d[15:8]  = wdata_q[7:0];
                2'd2:    merge_data_d[23:16] = wdata_q[7:0];
                2'd3:    merge_data_d[31:24] = wdata_q[7:0];
                default: merge_data_d[7:0]   = wdata_q[7:0];
            endcase
        end else if (size_q == 2'b01) begin
            if (addr_q[1]) merge_data_d[31:16] = wdata_q[15:0];
            else           merge_data_d[15:0]  = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            merge_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (req_bad_d) begin
                            state_q     <= S_ERR;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (req_we && req_size == 2'b10) begin
                            state_q <= S_WRITE;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: state_q <= S_CAPTURE;
                S_CAPTURE: begin
                    if (we_q) begin
                        merge_q <= merge_data_d;
                        state_q <= S_WRITE;
                    end else begin
                        rsp_rdata_q <= load_data_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_WRITE: begin
                    rsp_rdata_q <= '0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // RAM side is decoded from state only, so reset removes ram_wren without waiting for a clock.
    assign req_ready   = (state_q == S_IDLE);
    assign ram_wren    = (state_q == S_WRITE);
    assign ram_address = (state_q == S_IDLE) ? '0 : addr_q[RAM_ADDR_W+1:2];
    assign ram_data    = (state_q != S_WRITE) ? '0 :
                         (size_q == 2'b10)    ? wdata_q : merge_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: RAM model plus a byte-level reference memory.
// Directed spec scenarios, randomized traffic, reset abort and back-to-back accepts.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_wren;
    logic [29:0] ram_address;
    logic [31:0] ram_data;
    logic [31:0] ram_q;

    int checks;
    int failures;
    int wren_cnt;
    int rsp_cnt;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    mem_access_unit #(.ADDR_W(32), .RAM_ADDR_W(30)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .ram_wren(ram_wren), .ram_address(ram_address),
        .ram_data(ram_data), .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address[7:0]] <= ram_data;
        ram_q <= mem[ram_address[7:0]];
    end

    initial begin
        wren_cnt = 0;
        rsp_cnt  = 0;
    end
    always @(posedge clk) begin
        if (ram_wren)  wren_cnt <= wren_cnt + 1;
        if (rsp_valid) rsp_cnt  <= rsp_cnt + 1;
    end

    // Reference model: byte lanes of a plain word array, little-endian.
    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic sgn);
        logic [31:0] v;
        logic [31:0] mask;
        int sh;
        int nb;
        v = ref_mem[addr[9:2]];
        if (size == 2'd2) return v;
        sh   = int'(addr[1:0]) * 8;
        nb   = 8 << size;
        mask = (32'h1 << nb) - 32'h1;
        v    = (v >> sh) & mask;
        if (sgn && v[nb-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] wdata);
        logic [31:0] mask;
        int sh;
        sh   = int'(addr[1:0]) * 8;
        mask = (size == 2'd2) ? 32'hFFFF_FFFF : (((32'h1 << (8 << size)) - 32'h1) << sh);
        ref_mem[addr[9:2]] = (ref_mem[addr[9:2]] & ~mask) | ((wdata << sh) & mask);
    endtask

    function automatic logic ref_bad(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd3) return 1'b1;
        return (addr % (32'd1 << size)) != 0;
    endfunction

    // Drives one request, scrambles the inputs after acceptance and measures the response.
    task automatic do_txn(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int wr, output logic stuck);
        int wr0;
        @(negedge clk);
        for (int k = 0; k < 10 && !req_ready; k++) @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        wr0        = wren_cnt;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat   = -1;
        rdata = 'x;
        err   = 1'bx;
        stuck = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat   = n;
                rdata = rsp_rdata;
                err   = rsp_err;
                break;
            end
        end
        if (lat >= 0) begin
            @(negedge clk);
            stuck = rsp_valid;
        end
        wr = wren_cnt - wr0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rsp got ready=%b valid=%b err=%b rdata=%h exp ready=1 valid=0 err=0 rdata=0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if (ram_wren !== 1'b0 || ram_address !== 30'h0 || ram_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_ram got wren=%b addr=%h data=%h exp 0/0/0", ram_wren, ram_address, ram_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got ready=%b valid=%b exp ready=1 valid=0", req_ready, rsp_valid);
        end
        $display("txn reset ready=%b valid=%b", req_ready, rsp_valid);
    endtask

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
    } dir_t;

    task automatic test_directed;
        dir_t tab [15];
        logic [31:0] rdata;
        logic err;
        logic stuck;
        int lat;
        int wr;
        int exp_wr;
        tab = '{
            '{1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0,        1'b0, 4'd1},
            '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 1'b0, 4'd2},
            '{1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, 32'h0,        1'b0, 4'd1},
            '{1'b1, 2'd0, 1'b0, 32'h41, 32'h000000A5, 32'h0,        1'b0, 4'd3},
            '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'h1122A544, 1'b0, 4'd2},
            '{1'b0, 2'd0, 1'b1, 32'h41, 32'h0,        32'hFFFFFFA5, 1'b0, 4'd2},
            '{1'b0, 2'd0, 1'b0, 32'h41, 32'h0,        32'h000000A5, 1'b0, 4'd2},
            '{1'b1, 2'd1, 1'b0, 32'h42, 32'h00008001, 32'h0,        1'b0, 4'd3},
            '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'h8001A544, 1'b0, 4'd2},
            '{1'b0, 2'd1, 1'b1, 32'h42, 32'h0,        32'hFFFF8001, 1'b0, 4'd2},
            '{1'b0, 2'd1, 1'b0, 32'h40, 32'h0,        32'h0000A544, 1'b0, 4'd2},
            '{1'b0, 2'd2, 1'b0, 32'h42, 32'h0,        32'h0,        1'b1, 4'd0},
            '{1'b1, 2'd1, 1'b0, 32'h43, 32'h00001234, 32'h0,        1'b1, 4'd0},
            '{1'b0, 2'd3, 1'b0, 32'h40, 32'h0,        32'h0,        1'b1, 4'd0},
            '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'h8001A544, 1'b0, 4'd2}
        };
        for (int i = 0; i < 15; i++) begin
            do_txn(tab[i].we, tab[i].size, tab[i].sgn, tab[i].addr, tab[i].wdata, rdata, err, lat, wr, stuck);
            exp_wr = (tab[i].we && !tab[i].err) ? 1 : 0;
            if (tab[i].we && !tab[i].err) ref_store(tab[i].addr, tab[i].size, tab[i].wdata);
            $display("txn dir%0d we=%0d size=%0d addr=%h rdata=%h err=%0d lat=%0d wr=%0d",
                     i, tab[i].we, tab[i].size, tab[i].addr, rdata, err, lat, wr);
            checks++;
            if (lat !== int'(tab[i].lat)) begin
                failures++;
                $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, tab[i].lat);
            end
            checks++;
            if (rdata !== tab[i].rdata || err !== tab[i].err) begin
                failures++;
                $display("FAIL dir%0d_rsp got rdata=%h err=%b exp rdata=%h err=%b",
                         i, rdata, err, tab[i].rdata, tab[i].err);
            end
            checks++;
            if (wr !== exp_wr || stuck !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_wren_pulse got wren_cycles=%0d extra_valid=%b exp wren_cycles=%0d extra_valid=0",
                         i, wr, stuck, exp_wr);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  size;
        logic        we;
        logic        sgn;
        logic        err;
        logic        exp_err;
        logic        stuck;
        int lat;
        int wr;
        int exp_lat;
        for (int w = 0; w < 16; w++) begin
            wdata = $urandom;
            do_txn(1'b1, 2'd2, 1'b0, 32'(w * 4), wdata, rdata, err, lat, wr, stuck);
            ref_store(32'(w * 4), 2'd2, wdata);
        end
        for (int i = 0; i < 40; i++) begin
            we    = 1'($urandom);
            size  = 2'($urandom_range(0, 3));
            sgn   = 1'($urandom);
            addr  = 32'($urandom_range(0, 63));
            wdata = $urandom;
            exp_err   = ref_bad(addr, size);
            exp_lat   = exp_err ? 0 : (!we ? 2 : (size == 2'd2 ? 1 : 3));
            exp_rdata = (exp_err || we) ? 32'h0 : ref_load(addr, size, sgn);
            do_txn(we, size, sgn, addr, wdata, rdata, err, lat, wr, stuck);
            if (we && !exp_err) ref_store(addr, size, wdata);
            $display("txn rnd%0d we=%0d size=%0d sgn=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                     i, we, size, sgn, addr, wdata, rdata, err, lat);
            checks++;
            if (lat !== exp_lat || err !== exp_err) begin
                failures++;
                $display("FAIL rnd%0d_timing got lat=%0d err=%b exp lat=%0d err=%b", i, lat, err, exp_lat, exp_err);
            end
            checks++;
            if (rdata !== exp_rdata) begin
                failures++;
                $display("FAIL rnd%0d_rdata got=%h exp=%h", i, rdata, exp_rdata);
            end
            checks++;
            if (wr !== ((we && !exp_err) ? 1 : 0)) begin
                failures++;
                $display("FAIL rnd%0d_wren got=%0d exp=%0d", i, wr, (we && !exp_err) ? 1 : 0);
            end
        end
        for (int w = 0; w < 16; w++) begin
            checks++;
            if (mem[w] !== ref_mem[w]) begin
                failures++;
                $display("FAIL rnd_ram_word%0d got=%h exp=%h", w, mem[w], ref_mem[w]);
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rdata;
        logic err;
        logic stuck;
        int lat;
        int wr;
        int wr0;
        int rsp0;
        logic saw_valid;
        do_txn(1'b1, 2'd2, 1'b0, 32'h44, 32'h55667788, rdata, err, lat, wr, stuck);
        ref_store(32'h44, 2'd2, 32'h55667788);
        wr0  = wren_cnt;
        rsp0 = rsp_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd0;
        req_addr  = 32'h45;
        req_wdata = 32'h99;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (ram_wren !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_async got wren=%b ready=%b exp wren=0 ready=1", ram_wren, req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (rsp_valid) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0 || rsp_cnt != rsp0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_rsp got valid_seen=%b rsp_delta=%0d ready=%b exp 0/0/1",
                     saw_valid, rsp_cnt - rsp0, req_ready);
        end
        checks++;
        if (wren_cnt != wr0 || mem[8'h11] !== ref_mem[8'h11]) begin
            failures++;
            $display("FAIL abort_ram got wren_delta=%0d word=%h exp wren_delta=0 word=%h",
                     wren_cnt - wr0, mem[8'h11], ref_mem[8'h11]);
        end
        do_txn(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, rdata, err, lat, wr, stuck);
        $display("txn abort_reload addr=00000044 rdata=%h err=%0d lat=%0d", rdata, err, lat);
        checks++;
        if (rdata !== ref_load(32'h44, 2'd2, 1'b0) || lat != 2 || err !== 1'b0) begin
            failures++;
            $display("FAIL abort_next got rdata=%h lat=%0d err=%b exp rdata=%h lat=2 err=0",
                     rdata, lat, err, ref_load(32'h44, 2'd2, 1'b0));
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] plan [3];
        logic [31:0] exp_q [$];
        logic [31:0] exp_v;
        int accepts;
        int got;
        int cyc;
        int last_acc;
        accepts  = 0;
        got      = 0;
        cyc      = 0;
        last_acc = -1;
        for (int i = 0; i < 3; i++) plan[i] = 32'($urandom_range(0, 15) * 4);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = plan[0];
        while (got < 3 && cyc < 40) begin
            if (rsp_valid) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                $display("txn b2b%0d rdata=%h err=%0d", got, rsp_rdata, rsp_err);
                checks++;
                if (rsp_rdata !== exp_v || req_ready !== 1'b0 || rsp_err !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b%0d_rsp got rdata=%h ready=%b err=%b exp rdata=%h ready=0 err=0",
                             got, rsp_rdata, req_ready, rsp_err, exp_v);
                end
                got++;
            end
            if (req_valid && req_ready) begin
                exp_q.push_back(ref_load(req_addr, 2'd2, 1'b0));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 4) begin
                        failures++;
                        $display("FAIL b2b_accept_spacing got=%0d exp=4", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                accepts++;
            end
            @(posedge clk);
            #1;
            if (accepts >= 3) req_valid = 1'b0;
            else req_addr = req_ready ? plan[accepts] : $urandom;
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        checks++;
        if (got != 3 || accepts != 3) begin
            failures++;
            $display("FAIL b2b_count got responses=%0d accepts=%0d exp 3/3", got, accepts);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        test_reset();
        test_directed();
        test_random();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
